// File: rtl/csa_subtractor_pipe_if.sv
// Streaming operand/result bundle for the pipelined carry-select subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface csa_subtractor_pipe_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, zero, ovf
   );
endinterface

// File: rtl/csa_subtractor_pipe.sv
// Two-stage carry-select subtractor: diff = a - b - borrow_in via a + ~b + ~borrow_in,
// with valid/ready flow control and one operand set of skid capacity in stage 1.
module csa_subtractor_pipe #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   csa_subtractor_pipe_if.slave bus
);
   localparam int HALF = WIDTH / 2;

   logic            s1_valid_q, s1_valid_d;
   logic [HALF-1:0] d_lo_q, d_lo_d;
   logic [HALF-1:0] d_hi0_q, d_hi0_d;
   logic [HALF-1:0] d_hi1_q, d_hi1_d;
   logic            c_lo_q, c_lo_d;
   logic            c0_q, c0_d;
   logic            c1_q, c1_d;
   logic            a_msb_q, a_msb_d;
   logic            b_msb_q, b_msb_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic            s2_load;
   logic            in_xfer;
   logic [HALF:0]   sum_lo, sum_hi0, sum_hi1;
   logic [HALF-1:0] d_hi_sel;
   logic            carry_sel;

   assign s2_load     = !out_valid_q | bus.out_ready;
   assign bus.in_ready = !s1_valid_q | s2_load;
   assign in_xfer     = bus.in_valid & bus.in_ready;

   // Both upper-half candidates are formed in parallel; the low carry picks one in stage 2.
   always_comb begin
      sum_lo  = {1'b0, bus.a[HALF-1:0]} + {1'b0, ~bus.b[HALF-1:0]}
              + {{HALF{1'b0}}, ~bus.borrow_in};
      sum_hi0 = {1'b0, bus.a[WIDTH-1:HALF]} + {1'b0, ~bus.b[WIDTH-1:HALF]};
      sum_hi1 = {1'b0, bus.a[WIDTH-1:HALF]} + {1'b0, ~bus.b[WIDTH-1:HALF]}
              + {{HALF{1'b0}}, 1'b1};
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      d_lo_d     = d_lo_q;
      c_lo_d     = c_lo_q;
      d_hi0_d    = d_hi0_q;
      c0_d       = c0_q;
      d_hi1_d    = d_hi1_q;
      c1_d       = c1_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         {c_lo_d, d_lo_d}  = sum_lo;
         {c0_d, d_hi0_d}   = sum_hi0;
         {c1_d, d_hi1_d}   = sum_hi1;
         a_msb_d    = bus.a[WIDTH-1];
         b_msb_d    = bus.b[WIDTH-1];
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      d_hi_sel  = c_lo_q ? d_hi1_q : d_hi0_q;
      carry_sel = c_lo_q ? c1_q : c0_q;
   end

   // Result registers only change when stage 1 actually hands over an operand set.
   always_comb begin
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            diff_d   = {d_hi_sel, d_lo_q};
            borrow_d = ~carry_sel;
            zero_d   = ({d_hi_sel, d_lo_q} == '0);
            ovf_d    = (a_msb_q != b_msb_q) & (d_hi_sel[HALF-1] != a_msb_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         d_lo_q      <= '0;
         c_lo_q      <= 1'b0;
         d_hi0_q     <= '0;
         c0_q        <= 1'b0;
         d_hi1_q     <= '0;
         c1_q        <= 1'b0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         d_lo_q      <= d_lo_d;
         c_lo_q      <= c_lo_d;
         d_hi0_q     <= d_hi0_d;
         c0_q        <= c0_d;
         d_hi1_q     <= d_hi1_d;
         c1_q        <= c1_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.zero       = zero_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: doc/csa_subtractor_pipe.md
Name: csa_subtractor_pipe

Overview:
- Two-stage pipelined carry-select subtractor: computes diff = A − B − borrow_in on WIDTH-bit operands.
- Internally forms A + ~B + ~borrow_in, split into two halves.
- Stage 1 computes the low-half difference and both candidate upper halves (carry-in 0 and 1).
- Stage 2 selects the upper half with the registered low carry and derives the flags.
- Sits beside the existing combinational carry-select adder in the datapath; adds valid/ready flow control so it can run in a streaming ALU path.

Parameters:
- WIDTH, 64, operand/result width; must be even and ≥ 4.
- HALF, WIDTH/2, split point; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  incoming borrow (1 = subtract one more).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- diff  output  WIDTH  a − b − borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  1 when the unsigned result underflowed (= inverted final carry).
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid and out_valid clear to 0.
  - diff, borrow_out, zero and ovf clear to 0.
  - in_ready reads 1 as soon as reset releases.
  - Reset mid-operation discards all in-flight data; no partial result is emitted afterwards.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Stage 1 (registered on input transfer):
  - {c_lo, d_lo} = a[HALF-1:0] + ~b[HALF-1:0] + ~borrow_in.
  - {c0, d_hi0} = a[W-1:HALF] + ~b[W-1:HALF] + 0.
  - {c1, d_hi1} = a[W-1:HALF] + ~b[W-1:HALF] + 1.
  - Also register a[W-1] and b[W-1] for the overflow check.
- Stage 2:
  - d_hi = c_lo ? d_hi1 : d_hi0.
  - carry = c_lo ? c1 : c0.
  - diff = {d_hi, d_lo}; borrow_out = ~carry; zero = (diff == 0).
  - ovf = (a_msb != b_msb) & (diff[W-1] != a_msb).
- Flow control:
  - Stage 2 loads when !out_valid | out_ready.
  - Stage 1 advances into stage 2 under the same condition.
  - in_ready = !s1_valid | (!out_valid | out_ready).
  - Full throughput: one result per cycle when out_ready is held high.
- Latency: exactly 2 cycles from input transfer to out_valid, with no backpressure.
- Stall: while out_valid & !out_ready, diff and all flags hold stable.
  - Stage 1 holds up to one more operand set; in_ready drops only when both stages are full.
- Simultaneous events:
  - Output transfer and stage-1 advance in the same cycle: out_valid stays 1 with the new result.
  - If stage 1 is empty, out_valid drops to 0.
- Input change while in_valid & !in_ready is ignored; the producer must hold its data.
- Ordering: strict FIFO; no reordering or dropping of results.
- Output registers update only on a stage-2 load; no combinational path from a/b to the outputs.

Test Plan:
- Reset, then a=64'h0000_0000_0000_0005, b=3, borrow_in=0, out_ready=1 → two cycles later out_valid=1, diff=2, borrow_out=0, zero=0, ovf=0.
- a=0, b=1, borrow_in=0 → diff=64'hFFFF_FFFF_FFFF_FFFF, borrow_out=1; low-half borrow propagates through the select.
- a=64'h8000_0000_0000_0000, b=1 → diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, borrow_out=0. Then a=b=64'h1234_5678_9ABC_DEF0 with borrow_in=0 → zero=1.
- Back-to-back stream of 8 random operand sets with out_ready=1 → 8 consecutive out_valid cycles matching a golden model, in order.
- Hold out_ready=0 while feeding 3 sets:
  - first result holds stable and in_ready drops after the 2nd set is accepted;
  - then release out_ready → all 3 results emerge in order, none lost or duplicated.
- Assert rst_n low with both stages full → out_valid=0 immediately (asynchronous). After release, only newly supplied operands produce results.
